// File: rtl/ibex_rf_msg_loader.sv
// Message-input sequencer for the flip-flop register file: collects 1-4 words,
// checks legality and issues one atomic multi-register write, holding off core write-back collisions.
module ibex_rf_msg_loader #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [4:0]           req_base_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    input  logic [DataWidth-1:0] word_data_i,
    input  logic                 word_last_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_waddr_i,
    output logic                 rf_input_valid_o,
    output logic [4:0]           rf_input_addr_o,
    output logic [1:0]           rf_len_o,
    output logic [DataWidth-1:0] rf_input_data_o,
    output logic [DataWidth-1:0] rf_msg1_o,
    output logic [DataWidth-1:0] rf_msg2_o,
    output logic [DataWidth-1:0] rf_msg3_o,
    output logic                 stall_req_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam logic [5:0] MaxAddr = RV32E ? 6'd15 : 6'd31;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        ISSUE
    } state_e;

    state_e               state;
    logic [4:0]           base;
    logic [1:0]           cnt;
    logic [1:0]           len;
    logic                 ovf;
    logic [DataWidth-1:0] msg_buf [4];

    logic       in_issue;
    logic [5:0] end_addr;
    logic       illegal;
    logic       conflict;

    // Range arithmetic is done in 6 bits so base+len can never wrap past x31.
    assign in_issue = (state == ISSUE);
    assign end_addr = {1'b0, base} + {4'b0, len};
    assign illegal  = ovf || (base == 5'd0) || (end_addr > MaxAddr);
    assign conflict = core_we_i
                      && ({1'b0, core_waddr_i} >= {1'b0, base})
                      && ({1'b0, core_waddr_i} <= end_addr);

    // The issue decision depends on the core's same-cycle write, so these are not registered.
    assign rf_input_valid_o = in_issue && !illegal && !conflict;
    assign done_o           = in_issue && !illegal && !conflict;
    assign err_o            = in_issue && illegal;
    assign stall_req_o      = in_issue && !illegal && conflict;

    assign req_ready_o  = (state == IDLE);
    assign word_ready_o = (state == COLLECT) || (state == DRAIN);
    assign busy_o       = (state != IDLE);

    assign rf_input_addr_o = in_issue ? base : 5'd0;
    assign rf_len_o        = in_issue ? len  : 2'd0;
    assign rf_input_data_o = msg_buf[0];
    assign rf_msg1_o       = msg_buf[1];
    assign rf_msg2_o       = msg_buf[2];
    assign rf_msg3_o       = msg_buf[3];

    // NOTE: the word buffer is reset like any other state because its contents drive outputs directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            base  <= 5'd0;
            cnt   <= 2'd0;
            len   <= 2'd0;
            ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) msg_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        base  <= req_base_i;
                        cnt   <= 2'd0;
                        len   <= 2'd0;
                        ovf   <= 1'b0;
                        for (int i = 0; i < 4; i++) msg_buf[i] <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (word_valid_i) begin
                        msg_buf[cnt] <= word_data_i;
                        len          <= cnt;
                        if (cnt != 2'd3) cnt <= cnt + 2'd1;
                        if (word_last_i) begin
                            state <= ISSUE;
                        end else if (cnt == 2'd3) begin
                            ovf   <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (word_valid_i && word_last_i) state <= ISSUE;
                end
                ISSUE: begin
                    if (illegal || !conflict) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_msg_loader.sv
// Directed bench for ibex_rf_msg_loader: a 32-register and a 16-register instance share all stimulus.
module tb_ibex_rf_msg_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic [4:0]  req_base_i;
    logic        word_valid_i;
    logic [31:0] word_data_i;
    logic        word_last_i;
    logic        core_we_i;
    logic [4:0]  core_waddr_i;

    logic        req_ready, word_ready, rf_valid, stall, done, err, busy;
    logic [4:0]  rf_addr;
    logic [1:0]  rf_len;
    logic [31:0] rf_data, msg1, msg2, msg3;

    logic        e_req_ready, e_word_ready, e_rf_valid, e_stall, e_done, e_err, e_busy;
    logic [4:0]  e_rf_addr;
    logic [1:0]  e_rf_len;
    logic [31:0] e_rf_data, e_msg1, e_msg2, e_msg3;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_msg_loader #(.RV32E(1'b0), .DataWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready), .req_base_i(req_base_i),
        .word_valid_i(word_valid_i), .word_ready_o(word_ready),
        .word_data_i(word_data_i), .word_last_i(word_last_i),
        .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
        .rf_input_valid_o(rf_valid), .rf_input_addr_o(rf_addr), .rf_len_o(rf_len),
        .rf_input_data_o(rf_data), .rf_msg1_o(msg1), .rf_msg2_o(msg2), .rf_msg3_o(msg3),
        .stall_req_o(stall), .done_o(done), .err_o(err), .busy_o(busy)
    );

    ibex_rf_msg_loader #(.RV32E(1'b1), .DataWidth(32)) dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(e_req_ready), .req_base_i(req_base_i),
        .word_valid_i(word_valid_i), .word_ready_o(e_word_ready),
        .word_data_i(word_data_i), .word_last_i(word_last_i),
        .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
        .rf_input_valid_o(e_rf_valid), .rf_input_addr_o(e_rf_addr), .rf_len_o(e_rf_len),
        .rf_input_data_o(e_rf_data), .rf_msg1_o(e_msg1), .rf_msg2_o(e_msg2), .rf_msg3_o(e_msg3),
        .stall_req_o(e_stall), .done_o(e_done), .err_o(e_err), .busy_o(e_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic [4:0] b);
        req_valid_i = 1'b1;
        req_base_i  = b;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        word_valid_i = 1'b1;
        word_data_i  = d;
        word_last_i  = l;
        tick();
        word_valid_i = 1'b0;
        word_last_i  = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_base_i   = 5'd0;
        word_valid_i = 1'b0;
        word_data_i  = 32'd0;
        word_last_i  = 1'b0;
        core_we_i    = 1'b0;
        core_waddr_i = 5'd0;

        // Reset values
        #13;
        chk("rst req_ready", req_ready, 1);
        chk("rst word_ready", word_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", rf_valid, 0);
        chk("rst stall/done/err", {stall, done, err}, 0);
        chk("rst addr/len", {rf_addr, rf_len}, 0);
        chk("rst data", rf_data | msg1 | msg2 | msg3, 0);
        rst_ni = 1'b1;
        tick();

        // Word offered in IDLE is not consumed
        word_valid_i = 1'b1;
        #1;
        chk("idle word_ready", word_ready, 0);
        word_valid_i = 1'b0;

        // Single word at x5: strobe in cycle 2
        send_req(5'd5);
        chk("single busy", busy, 1);
        chk("single word_ready", word_ready, 1);
        send_word(32'hA5A5_0001, 1'b1);
        #1;
        chk("single valid", rf_valid, 1);
        chk("single done", done, 1);
        chk("single err", err, 0);
        chk("single addr", rf_addr, 5);
        chk("single len", rf_len, 0);
        chk("single data", rf_data, 32'hA5A5_0001);
        chk("single msg1", msg1, 0);
        tick();
        chk("single ready again", req_ready, 1);
        chk("single valid low", rf_valid, 0);
        chk("single addr idle", rf_addr, 0);

        // Four words at x8
        send_req(5'd8);
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b0);
        send_word(32'h44, 1'b1);
        #1;
        chk("four valid", rf_valid, 1);
        chk("four addr", rf_addr, 8);
        chk("four len", rf_len, 3);
        chk("four data", rf_data, 32'h11);
        chk("four msg1", msg1, 32'h22);
        chk("four msg2", msg2, 32'h33);
        chk("four msg3", msg3, 32'h44);
        tick();

        // Buffer cleared on accept: stale words must not leak into msg1..3
        send_req(5'd2);
        send_word(32'h77, 1'b1);
        #1;
        chk("clear data", rf_data, 32'h77);
        chk("clear msg1..3", msg1 | msg2 | msg3, 0);
        tick();

        // Conflict: core writes x11 while a 3-word message at x10 waits
        send_req(5'd10);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd11;
        send_word(32'hC0, 1'b0);
        send_word(32'hC1, 1'b0);
        send_word(32'hC2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("conflict stall", stall, 1);
            chk("conflict no strobe", {rf_valid, done}, 0);
            chk("conflict addr stable", rf_addr, 10);
            tick();
        end
        core_we_i = 1'b0;
        #1;
        chk("conflict stall released", stall, 0);
        chk("conflict strobe", rf_valid, 1);
        chk("conflict len", rf_len, 2);
        chk("conflict words", {rf_data[7:0], msg1[7:0], msg2[7:0]}, 32'h00C0C1C2);
        tick();

        // Core write just past the range (x13 vs x10..x12): no stall
        send_req(5'd10);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd13;
        send_word(32'hD0, 1'b0);
        send_word(32'hD1, 1'b0);
        send_word(32'hD2, 1'b1);
        #1;
        chk("no conflict stall", stall, 0);
        chk("no conflict strobe", rf_valid, 1);
        core_waddr_i = 5'd12;
        #1;
        chk("upper edge conflict", stall, 1);
        core_we_i = 1'b0;
        #1;
        tick();
        chk("upper edge idle", busy, 0);

        // Illegal: base 0
        send_req(5'd0);
        send_word(32'h5, 1'b1);
        #1;
        chk("base0 err", err, 1);
        chk("base0 no strobe", {rf_valid, done}, 0);
        tick();
        chk("base0 idle", busy, 0);
        chk("base0 err one cycle", err, 0);

        // Illegal: x30 + 3 words runs past x31
        send_req(5'd30);
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b1);
        #1;
        chk("base30 err", err, 1);
        chk("base30 no strobe", rf_valid, 0);
        tick();

        // RV32E boundary: x14..x15 legal, x15..x16 illegal only on the 16-register instance
        send_req(5'd14);
        send_word(32'hE0, 1'b0);
        send_word(32'hE1, 1'b1);
        #1;
        chk("e base14 done", e_done, 1);
        chk("e base14 err", e_err, 0);
        tick();
        send_req(5'd15);
        send_word(32'hF0, 1'b0);
        send_word(32'hF1, 1'b1);
        #1;
        chk("e base15 err", e_err, 1);
        chk("e base15 no strobe", e_rf_valid, 0);
        chk("base15 legal on 32 regs", done, 1);
        tick();

        // Overflow: 6 words, 5th and 6th drained, single err pulse
        send_req(5'd4);
        send_word(32'h40, 1'b0);
        send_word(32'h41, 1'b0);
        send_word(32'h42, 1'b0);
        send_word(32'h43, 1'b0);
        chk("ovf draining", {busy, word_ready}, 2'b11);
        send_word(32'h44, 1'b0);
        send_word(32'h45, 1'b1);
        #1;
        chk("ovf err", err, 1);
        chk("ovf no strobe", rf_valid, 0);
        chk("ovf msg3 not overwritten", msg3, 32'h43);
        tick();
        chk("ovf err once", err, 0);
        chk("ovf idle", req_ready, 1);

        // Reset during COLLECT after two words
        send_req(5'd6);
        send_word(32'h60, 1'b0);
        send_word(32'h61, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("midrst ready", {req_ready, word_ready, busy}, 3'b100);
        chk("midrst data", rf_data | msg1, 0);
        chk("midrst no strobe", rf_valid, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        send_req(5'd7);
        send_word(32'h99, 1'b1);
        #1;
        chk("after rst strobe", rf_valid, 1);
        chk("after rst addr", rf_addr, 7);
        chk("after rst data", rf_data, 32'h99);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_rf_msg_loader.md
# ibex_rf_msg_loader

Sequencer for the flip-flop register file's bulk message-input port (input_valid / len / base address / data + msg1..msg3). It accepts a message request (base register) and a stream of 1 to 4 data words, buffers them, checks legality, and issues one atomic multi-register write. The issue is held off while the core write port targets any register in the message range, because the register file gives the core write port per-register priority and a collision would silently drop a message word.

## Interface
- RV32E, 0: 1 gives 16 registers (MaxAddr = 15); 0 gives 32 registers (MaxAddr = 31).
- DataWidth, 32: word width. It must equal 32 to match the register file's message port.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  message request valid.
- req_ready_o  out  1  request accepted when both valid and ready are 1 (IDLE only).
- req_base_i  in  5  first destination register.
- word_valid_i  in  1  data word valid.
- word_ready_o  out  1  word accepted when both valid and ready are 1.
- word_data_i  in  DataWidth  data word.
- word_last_i  in  1  marks the final word of the message.
- core_we_i  in  1  core write-port enable (same-cycle copy of the register file's we_a).
- core_waddr_i  in  5  core write address.
- rf_input_valid_o  out  1  one-cycle message-write strobe to the register file.
- rf_input_addr_o  out  5  base register.
- rf_len_o  out  2  word count minus 1.
- rf_input_data_o  out  DataWidth  word 0, written to base.
- rf_msg1_o / rf_msg2_o / rf_msg3_o  out  DataWidth  words 1..3, written to base+1..base+3.
- stall_req_o  out  1  asks the core to hold its write-back.
- done_o  out  1  one-cycle pulse when a message is written.
- err_o  out  1  one-cycle pulse when a message is dropped.
- busy_o  out  1  state is not IDLE.

## Operation
- States: IDLE, COLLECT, DRAIN, ISSUE.
- IDLE:
  - req_ready_o=1, word_ready_o=0.
  - On request handshake: latch base, clear cnt and ovf, go to COLLECT.
- COLLECT:
  - word_ready_o=1.
  - Each word handshake writes buf[cnt] and increments cnt (2-bit, saturating at 3 after the 4th word).
  - Word with last=1 goes to ISSUE.
  - 4th word with last=0 sets ovf and goes to DRAIN.
- DRAIN:
  - word_ready_o=1; words are discarded.
  - Word with last=1 goes to ISSUE with ovf=1.
- ISSUE:
  - word_ready_o=0. len = number of words minus 1.
  - illegal = ovf OR base==0 OR (base + len) > MaxAddr. The sum is 6-bit, so there is no wrap.
  - If illegal: err_o=1 for 1 cycle, no strobe, go to IDLE.
  - conflict = core_we_i AND core_waddr_i ≥ base AND core_waddr_i ≤ base + len. Combinational, evaluated every cycle.
  - If conflict: stall_req_o=1, hold in ISSUE, outputs stable.
  - If no conflict: rf_input_valid_o=1 and done_o=1 for that cycle, go to IDLE.
- Data outputs: rf_input_data_o/msgN drive buf[0..3]. Entries beyond len are zero (buffer cleared on request accept).
- rf_input_addr_o and rf_len_o are driven in ISSUE only; they are 0 otherwise.
- Requests and words are never accepted in the same cycle. A word presented in IDLE is not consumed.

## Timing
- Reset values while rst_ni=0:
  - State IDLE; buf, cnt, base, ovf = 0.
  - rf_input_valid_o, stall_req_o, done_o, err_o, busy_o, word_ready_o = 0.
  - req_ready_o = 1; all data/address outputs = 0.
- Reset asserted mid-message: immediate return to IDLE, message discarded, no strobe.
- Latency: request accepted in cycle 0; N words back-to-back in cycles 1..N; strobe in cycle N+1 if there is no conflict; req_ready_o=1 again in cycle N+2.
- Best-case throughput: one N-word message per N+2 cycles.
- Conflict hold has no timeout. The strobe fires in the first cycle in which conflict=0.
- stall_req_o is combinational from state and core inputs, with no registered delay.
- done_o and err_o never assert in the same cycle. Exactly one of them pulses per accepted request, unless reset intervenes.

## Test plan
- Single word: base=5, word 0xA5A5_0001 with last=1 -> cycle 2: strobe, addr=5, len=0, data=0xA5A5_0001, done_o=1. Register x5 reads back 0xA5A5_0001.
- Four words: base=8, words 0x11,0x22,0x33,0x44, last on 4th -> len=3, msg1..3 = 0x22/0x33/0x44. x8..x11 hold 0x11..0x44.
- Conflict: 3-word message at base=10, core_we_i=1 with waddr=11 for 3 cycles in ISSUE -> stall_req_o=1 for 3 cycles, strobe in the 4th cycle, all three registers correct. Repeat with waddr=13 -> no stall.
- Illegal: base=0 with 1 word -> err_o pulse, no strobe. base=30 with 3 words -> err_o. With RV32E=1, base=14 with 2 words is legal and base=15 with 2 words gives err_o.
- Overflow: 6 words at base=4, last on 6th -> words 5–6 drained, err_o once, x4..x7 unchanged.
- Reset during COLLECT after 2 words -> all outputs at reset values, no strobe. The next message completes normally.
